framebuffer_ctrl: RTL and testbench

- Pixel framebuffer storage that sits directly upstream of the VGA output stage.
- Serves that stage's pixel read port with one-cycle registered latency.
- Accepts CPU pixel writes through a small valid/ready write queue.
- Includes a hardware clear-screen engine that fills every pixel with one colour, one pixel per clock.

---
 rtl/fb_pkg.sv | 10 +
 rtl/framebuffer_ctrl_if.sv | 23 ++
 rtl/fb_write_fifo.sv | 35 +++
 rtl/framebuffer_ctrl.sv | 78 +++++++
 tb/tb_framebuffer_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer defaults and clear-engine state encoding
package fb_pkg;
   localparam int DEFAULT_BITS_PER_PIXEL = 3;
   localparam int DEFAULT_FRAMEBUFFER_DEPTH = 640 * 480;
   localparam int FB_ADDR_WIDTH = $clog2(DEFAULT_FRAMEBUFFER_DEPTH);
   typedef enum logic {
      STATE_IDLE  = 1'b0,
      STATE_CLEAR = 1'b1
   } clear_state_t;
endpackage

// File: rtl/framebuffer_ctrl_if.sv
// framebuffer_ctrl_if: VGA read port, CPU write queue and clear-engine signals
interface framebuffer_ctrl_if import fb_pkg::*; #(
   parameter int BITS_PER_PIXEL = DEFAULT_BITS_PER_PIXEL
);
   logic [31:0]               i_Fb_Read_Addr;
   logic [BITS_PER_PIXEL-1:0] o_Fb_Read_Data;
   logic                      i_Wr_Valid;
   logic                      o_Wr_Ready;
   logic [31:0]               i_Wr_Addr;
   logic [BITS_PER_PIXEL-1:0] i_Wr_Data;
   logic                      i_Clear_Start;
   logic [BITS_PER_PIXEL-1:0] i_Clear_Color;
   logic                      o_Clear_Busy;
   logic                      o_Wr_Error;
   modport master (
      output i_Fb_Read_Addr, i_Wr_Valid, i_Wr_Addr, i_Wr_Data, i_Clear_Start, i_Clear_Color,
      input  o_Fb_Read_Data, o_Wr_Ready, o_Clear_Busy, o_Wr_Error
   );
   modport slave (
      input  i_Fb_Read_Addr, i_Wr_Valid, i_Wr_Addr, i_Wr_Data, i_Clear_Start, i_Clear_Color,
      output o_Fb_Read_Data, o_Wr_Ready, o_Clear_Busy, o_Wr_Error
   );
endinterface

// File: rtl/fb_write_fifo.sv
// fb_write_fifo: synchronous FIFO holding pending CPU pixel writes {addr, data}
module fb_write_fifo import fb_pkg::*; #(
   parameter int WIDTH = 32 + DEFAULT_BITS_PER_PIXEL,
   parameter int DEPTH = 4
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [WIDTH-1:0] slots [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign rd_data = slots[rd_ptr[PTR_W-1:0]];
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end
   always_ff @(posedge i_Clock) begin
      if (push && !full) slots[wr_ptr[PTR_W-1:0]] <= wr_data;
   end
endmodule

// File: rtl/framebuffer_ctrl.sv
// framebuffer_ctrl: pixel store with registered VGA read port, queued CPU writes
// and a one-pixel-per-clock clear-screen engine.
module framebuffer_ctrl import fb_pkg::*; #(
   parameter int BITS_PER_PIXEL    = DEFAULT_BITS_PER_PIXEL,
   parameter int FRAMEBUFFER_DEPTH = DEFAULT_FRAMEBUFFER_DEPTH,
   parameter int WRITE_FIFO_DEPTH  = 4
) (
   input logic i_Clock,
   input logic i_Reset,
   framebuffer_ctrl_if.slave bus
);
   localparam int ADDR_W  = $clog2(FRAMEBUFFER_DEPTH);
   localparam int ENTRY_W = 32 + BITS_PER_PIXEL;
   logic [BITS_PER_PIXEL-1:0] mem [FRAMEBUFFER_DEPTH];
   clear_state_t              state_q, state_d;
   logic [ADDR_W-1:0]         cnt_q, cnt_d;
   logic [BITS_PER_PIXEL-1:0] color_q, color_d;
   logic [BITS_PER_PIXEL-1:0] rd_data_q;
   logic                      err_q;
   logic                      fifo_full, fifo_empty, pop, mem_we, head_in_range;
   logic [ENTRY_W-1:0]        head;
   logic [31:0]               head_addr;
   logic [BITS_PER_PIXEL-1:0] head_data;
   logic [ADDR_W-1:0]         mem_addr;
   logic [BITS_PER_PIXEL-1:0] mem_data;
   fb_write_fifo #(.WIDTH(ENTRY_W), .DEPTH(WRITE_FIFO_DEPTH)) u_fifo (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .push    (bus.i_Wr_Valid && !fifo_full),
      .pop     (pop),
      .wr_data ({bus.i_Wr_Addr, bus.i_Wr_Data}),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );
   assign {head_addr, head_data} = head;
   assign bus.o_Wr_Ready     = !fifo_full;
   assign bus.o_Clear_Busy   = state_q == STATE_CLEAR;
   assign bus.o_Wr_Error     = err_q;
   assign bus.o_Fb_Read_Data = rd_data_q;
   // The clear engine owns the single memory write port; the queue drains only in IDLE.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      color_d       = color_q;
      pop           = (state_q == STATE_IDLE) && !fifo_empty;
      head_in_range = head_addr < 32'(FRAMEBUFFER_DEPTH);
      mem_we        = (state_q == STATE_CLEAR) || (pop && head_in_range);
      mem_addr      = (state_q == STATE_CLEAR) ? cnt_q : head_addr[ADDR_W-1:0];
      mem_data      = (state_q == STATE_CLEAR) ? color_q : head_data;
      if (state_q == STATE_IDLE && bus.i_Clear_Start) begin
         state_d = STATE_CLEAR;
         cnt_d   = '0;
         color_d = bus.i_Clear_Color;
      end else if (state_q == STATE_CLEAR) begin
         cnt_d   = cnt_q + ADDR_W'(1);
         state_d = (cnt_q == ADDR_W'(FRAMEBUFFER_DEPTH - 1)) ? STATE_IDLE : STATE_CLEAR;
      end
   end
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= STATE_IDLE;
         cnt_q     <= '0;
         color_q   <= '0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         color_q   <= color_d;
         err_q     <= err_q || (pop && !head_in_range);
         rd_data_q <= (bus.i_Fb_Read_Addr < 32'(FRAMEBUFFER_DEPTH)) ? mem[bus.i_Fb_Read_Addr[ADDR_W-1:0]] : '0;
      end
   end
   always_ff @(posedge i_Clock) begin
      if (mem_we) mem[mem_addr] <= mem_data;
   end
endmodule

// File: tb/tb_framebuffer_ctrl.sv
// tb_framebuffer_ctrl: directed stimulus with a queue-based scoreboard and negedge monitor
module tb_framebuffer_ctrl;
   localparam int BPP   = 3;
   localparam int DEPTH = 16;
   localparam int FD    = 4;
   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } st_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rd_req = 1'b0;
   logic rd_vld;
   logic [BPP-1:0] rd_q [$];
   string          rd_name [$];
   st_t            st_q [$];
   st_t            st;
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   framebuffer_ctrl_if #(.BITS_PER_PIXEL(BPP)) bus ();
   framebuffer_ctrl #(
      .BITS_PER_PIXEL    (BPP),
      .FRAMEBUFFER_DEPTH (DEPTH),
      .WRITE_FIFO_DEPTH  (FD)
   ) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .bus     (bus)
   );
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic status(input string name, input int sel, input logic e);
      st_q.push_back('{name, sel, 32'(e)});
   endtask
   task automatic rd(input logic [31:0] a, input logic [BPP-1:0] e, input string name);
      bus.i_Fb_Read_Addr = a;
      rd_req = 1'b1;
      rd_q.push_back(e);
      rd_name.push_back(name);
      tick;
      rd_req = 1'b0;
   endtask
   task automatic wr(input logic [31:0] a, input logic [BPP-1:0] d);
      bus.i_Wr_Valid = 1'b1;
      bus.i_Wr_Addr  = a;
      bus.i_Wr_Data  = d;
      for (int n = 0; n < 60 && !bus.o_Wr_Ready; n++) tick;
      if (!bus.o_Wr_Ready) cmp("wr_timeout", 32'd0, 32'd1);
      tick;
      bus.i_Wr_Valid = 1'b0;
   endtask
   function automatic logic [BPP-1:0] clear_exp(input int i);
      return (i == 1) ? 3'b100 : (i == 2) ? 3'b011 : (i == 4) ? 3'b101 : (i == 9) ? 3'b110 : 3'b010;
   endfunction
   function automatic logic [BPP-1:0] abort_exp(input int i);
      return (i <= 2) ? 3'b001 : (i == 4) ? 3'b101 : 3'b010;
   endfunction
   always @(posedge clk or posedge rst) rd_vld <= rst ? 1'b0 : rd_req;
   // Monitor: one registered read result per issued read, plus queued status checks.
   always @(negedge clk) begin
      if (rd_vld) begin
         if (rd_q.size() == 0) cmp("rd_unexpected", 32'd1, 32'd0);
         else cmp(rd_name.pop_front(), 32'(bus.o_Fb_Read_Data), 32'(rd_q.pop_front()));
      end
      while (st_q.size() > 0) begin
         st = st_q.pop_front();
         cmp(st.name, (st.sel == 0) ? 32'(bus.o_Wr_Ready) : (st.sel == 1) ? 32'(bus.o_Clear_Busy) : 32'(bus.o_Wr_Error), st.exp);
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      bus.i_Fb_Read_Addr = '0;
      bus.i_Wr_Valid     = 1'b0;
      bus.i_Wr_Addr      = '0;
      bus.i_Wr_Data      = '0;
      bus.i_Clear_Start  = 1'b0;
      bus.i_Clear_Color  = '0;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_rd_data", 32'(bus.o_Fb_Read_Data), 32'd0);
      status("rst_ready", 0, 1'b1);
      status("rst_busy", 1, 1'b0);
      status("rst_err", 2, 1'b0);
      rst = 1'b0;
      tick;
      wr(5, 3'b101);
      status("wr_ready", 0, 1'b1);
      status("wr_busy", 1, 1'b0);
      status("wr_err", 2, 1'b0);
      tick;
      rd(5, 3'b101, "rd5");
      wr(0, 3'b110);
      wr(16, 3'b001);
      tick;
      tick;
      rd(16, 3'b000, "rd_oor16");
      rd(307200, 3'b000, "rd_oor307200");
      rd(0, 3'b110, "rd0_untouched");
      status("err_set", 2, 1'b1);
      repeat (3) tick;
      status("err_held", 2, 1'b1);
      wr(7, 3'b011);
      tick;
      tick;
      wr(7, 3'b100);
      rd(7, 3'b011, "rbw_old");
      rd(7, 3'b100, "rbw_new");
      bus.i_Clear_Color = 3'b010;
      bus.i_Clear_Start = 1'b1;
      tick;
      bus.i_Clear_Start = 1'b0;
      fork
         begin
            int busy_cycles;
            busy_cycles = 0;
            while (bus.o_Clear_Busy && busy_cycles < 100) begin
               busy_cycles++;
               tick;
            end
            cmp("busy_cycles", 32'(busy_cycles), 32'd16);
         end
         begin
            tick;
            tick;
            bus.i_Clear_Color = 3'b111;
            bus.i_Clear_Start = 1'b1;
            tick;
            bus.i_Clear_Start = 1'b0;
            wr(1, 3'b001);
            wr(2, 3'b011);
            wr(1, 3'b100);
            wr(4, 3'b101);
            status("ready_full", 0, 1'b0);
            status("busy_during", 1, 1'b1);
            wr(9, 3'b110);
         end
      join
      repeat (8) tick;
      for (int i = 0; i < DEPTH; i++) rd(i, clear_exp(i), $sformatf("clear_rd%0d", i));
      status("post_clear_ready", 0, 1'b1);
      status("post_clear_busy", 1, 1'b0);
      bus.i_Clear_Color = 3'b001;
      bus.i_Clear_Start = 1'b1;
      tick;
      bus.i_Clear_Start = 1'b0;
      wr(4, 3'b111);
      wr(5, 3'b111);
      tick;
      #3;
      rst = 1'b1;
      #1;
      cmp("rst_async_busy", 32'(bus.o_Clear_Busy), 32'd0);
      cmp("rst_async_ready", 32'(bus.o_Wr_Ready), 32'd1);
      cmp("rst_async_err", 32'(bus.o_Wr_Error), 32'd0);
      cmp("rst_async_rd", 32'(bus.o_Fb_Read_Data), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick;
      tick;
      for (int i = 0; i < 6; i++) rd(i, abort_exp(i), $sformatf("abort_rd%0d", i));
      status("abort_ready", 0, 1'b1);
      status("abort_busy", 1, 1'b0);
      status("abort_err", 2, 1'b0);
      repeat (3) tick;
      cmp("rd_q_drained", 32'(rd_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
